// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-path arbiter and response router.
// Holds the RRESP encoding and the grant-vector index helper.
package axi_pkg;

    localparam int AXI_RESP_W = 2;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    // Lowest set bit wins, so a multi-hot vector still maps to one index.
    function automatic int onehot2bin(input logic [31:0] oh, input int n);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (i < n && oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// Full and empty come from the count register rather than from the pointers.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_r_resp_router.sv
// Routes shared-slave R beats back to the master that won each AR handshake.
// Grant indices queue in AR order; the head steers beats until RLAST.
module axi_r_resp_router
    import axi_pkg::*;
#(
    parameter int NUM_MST    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MST-1:0]           ar_grant,
    input  logic                         ar_valid,
    input  logic                         ar_ready,
    output logic                         ar_block,
    input  logic                         s_rvalid,
    output logic                         s_rready,
    input  logic [DATA_WIDTH-1:0]        s_rdata,
    input  logic [AXI_RESP_W-1:0]        s_rresp,
    input  logic                         s_rlast,
    input  logic [ID_WIDTH-1:0]          s_rid,
    output logic [NUM_MST-1:0]           m_rvalid,
    input  logic [NUM_MST-1:0]           m_rready,
    output logic [DATA_WIDTH-1:0]        m_rdata,
    output logic [AXI_RESP_W-1:0]        m_rresp,
    output logic                         m_rlast,
    output logic [ID_WIDTH-1:0]          m_rid,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         err_orphan,
    output logic                         err_grant
);

    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    logic          ar_hs;
    logic          grant_nz;
    logic          grant_ok;
    logic          push;
    logic          pop;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          nonempty;

    assign ar_hs    = ar_valid & ar_ready & ~ar_block;
    assign grant_nz = (ar_grant != '0);
    assign grant_ok = grant_nz &&
                      ((ar_grant & (ar_grant - NUM_MST'(1))) == '0);
    assign push     = ar_hs & grant_nz;
    assign push_idx = IW'(onehot2bin(32'(ar_grant), NUM_MST));

    sync_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTST)
    ) u_idx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_idx),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outst_cnt)
    );

    // Full is a register decode, so blocking never loops back through ARVALID.
    assign ar_block = fifo_full;
    assign nonempty = ~fifo_empty;
    assign s_rready = nonempty & m_rready[head];
    assign pop      = s_rvalid & s_rready & s_rlast;

    always_comb begin
        m_rvalid = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            m_rvalid[i] = s_rvalid & nonempty & (head == IW'(i));
        end
    end

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
            err_grant  <= 1'b0;
        end else begin
            if (s_rvalid && !nonempty) err_orphan <= 1'b1;
            if (ar_hs && !grant_ok)    err_grant  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_r_resp_router.sv
// Directed bench for axi_r_resp_router with hand-computed expectations.
// Inputs change on the falling edge; checks follow 1ns later.
module tb_axi_r_resp_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ar_grant;
    logic        ar_valid;
    logic        ar_ready;
    logic        ar_block;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [3:0]  m_rid;
    logic [2:0]  outst_cnt;
    logic        err_orphan;
    logic        err_grant;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_r_resp_router dut (
        .clk        (clk),
        .rst        (rst),
        .ar_grant   (ar_grant),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_block   (ar_block),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rlast    (s_rlast),
        .s_rid      (s_rid),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast),
        .m_rid      (m_rid),
        .outst_cnt  (outst_cnt),
        .err_orphan (err_orphan),
        .err_grant  (err_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ar_issue(input logic [1:0] g);
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        ar_grant = g;
        cyc();
        ar_valid = 1'b0;
        ar_grant = 2'b00;
    endtask

    task automatic beat(input string tag, input logic [31:0] d,
                        input logic last, input logic [1:0] exp_v);
        s_rvalid = 1'b1;
        s_rdata  = d;
        s_rlast  = last;
        s_rid    = d[3:0];
        #1;
        chk({tag, "_mrvalid"}, 32'(m_rvalid), 32'(exp_v));
        chk({tag, "_srready"}, 32'(s_rready), 32'd1);
        chk({tag, "_rdata"}, m_rdata, d);
        cyc();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ar_grant = 2'b00;
        ar_valid = 1'b0;
        ar_ready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'd0;
        s_rlast  = 1'b0;
        s_rid    = '0;
        m_rready = 2'b11;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_cnt", 32'(outst_cnt), 0);
        chk("rst_block", 32'(ar_block), 0);
        chk("rst_srready", 32'(s_rready), 0);
        chk("rst_mrvalid", 32'(m_rvalid), 0);
        chk("rst_errs", {30'd0, err_orphan, err_grant}, 0);

        // single burst to M1
        m_rready = 2'b10;
        ar_issue(2'b10);
        chk("sb_cnt1", 32'(outst_cnt), 1);
        for (int b = 0; b < 4; b++)
            beat("sb", 32'h10 + 32'(b), b == 3, 2'b10);
        #1;
        chk("sb_cnt0", 32'(outst_cnt), 0);

        // interleaved M0, M1, M0 with 2-beat bursts
        m_rready = 2'b11;
        ar_issue(2'b01);
        ar_issue(2'b10);
        ar_issue(2'b01);
        chk("il_cnt3", 32'(outst_cnt), 3);
        beat("il0", 32'h20, 1'b0, 2'b01);
        beat("il1", 32'h21, 1'b1, 2'b01);
        chk("il_cnt2", 32'(outst_cnt), 2);
        beat("il2", 32'h22, 1'b0, 2'b10);
        beat("il3", 32'h23, 1'b1, 2'b10);
        beat("il4", 32'h24, 1'b0, 2'b01);
        beat("il5", 32'h25, 1'b1, 2'b01);
        chk("il_cnt0", 32'(outst_cnt), 0);

        // fill to capacity, then a blocked 5th AR
        for (int k = 0; k < 4; k++) ar_issue(2'b01);
        chk("full_cnt", 32'(outst_cnt), 4);
        chk("full_block", 32'(ar_block), 1);
        ar_issue(2'b10);
        chk("full_nopush", 32'(outst_cnt), 4);
        // pop while an AR is still offered: no push that cycle
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        ar_grant = 2'b10;
        #1;
        chk("full_blk_pop", 32'(ar_block), 1);
        beat("full_pop", 32'h30, 1'b1, 2'b01);
        ar_valid = 1'b0;
        #1;
        chk("full_unblock", 32'(ar_block), 0);
        chk("full_cnt3", 32'(outst_cnt), 3);
        for (int k = 0; k < 3; k++) beat("drain", 32'h31 + 32'(k), 1'b1, 2'b01);
        #1;
        chk("drain_cnt0", 32'(outst_cnt), 0);

        // backpressure on M0 mid-burst
        ar_issue(2'b01);
        m_rready = 2'b01;
        beat("bp0", 32'hA0, 1'b0, 2'b01);
        s_rvalid = 1'b1;
        s_rdata  = 32'hA1;
        m_rready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall_rdy", 32'(s_rready), 0);
            chk("bp_stall_v", 32'(m_rvalid), 32'b01);
            cyc();
        end
        m_rready = 2'b01;
        beat("bp1", 32'hA1, 1'b0, 2'b01);
        beat("bp2", 32'hA2, 1'b0, 2'b01);
        beat("bp3", 32'hA3, 1'b1, 2'b01);
        #1;
        chk("bp_cnt0", 32'(outst_cnt), 0);

        // simultaneous push and pop at count 2
        m_rready = 2'b11;
        ar_issue(2'b01);
        ar_issue(2'b10);
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        ar_grant = 2'b01;
        beat("pp_pop", 32'h40, 1'b1, 2'b01);
        ar_valid = 1'b0;
        #1;
        chk("pp_cnt2", 32'(outst_cnt), 2);
        beat("pp_m1", 32'h41, 1'b1, 2'b10);
        beat("pp_m0", 32'h42, 1'b1, 2'b01);
        #1;
        chk("pp_cnt0", 32'(outst_cnt), 0);

        // orphan beat
        s_rvalid = 1'b1;
        #1;
        chk("orph_rdy", 32'(s_rready), 0);
        chk("orph_v", 32'(m_rvalid), 0);
        cyc();
        s_rvalid = 1'b0;
        cyc();
        chk("orph_sticky", 32'(err_orphan), 1);

        // zero and multi-hot grants
        ar_issue(2'b00);
        chk("g0_err", 32'(err_grant), 1);
        chk("g0_cnt", 32'(outst_cnt), 0);
        ar_issue(2'b11);
        chk("g11_cnt", 32'(outst_cnt), 1);
        beat("g11_route", 32'h50, 1'b1, 2'b01);

        // reset mid-burst
        ar_issue(2'b10);
        beat("mid", 32'h60, 1'b0, 2'b10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_cnt", 32'(outst_cnt), 0);
        chk("mrst_errs", {30'd0, err_orphan, err_grant}, 0);
        s_rvalid = 1'b1;
        #1;
        chk("mrst_rdy", 32'(s_rready), 0);
        cyc();
        s_rvalid = 1'b0;
        chk("mrst_orph", 32'(err_orphan), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axi_r_resp_router.md
Name: axi_r_resp_router

Overview:
- Return-path companion to the bus round-robin read-address arbiter: routes read-data (R) beats from the single shared slave back to the master that won AR arbitration.
- Records the granted master index in an in-order FIFO at each AR handshake.
- Steers R beats to the master at the FIFO head until the RLAST handshake.
- Blocks new AR issue when the outstanding-transaction capacity is exhausted.

Parameters:
- NUM_MST, 2, number of masters; equals the arbiter request width.
- DATA_WIDTH, 32, RDATA width.
- ID_WIDTH, 4, RID width.
- MAX_OUTST, 4, maximum outstanding read bursts (FIFO depth); power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ar_grant  in  NUM_MST  one-hot grant from the read-address arbiter.
- ar_valid  in  1  ARVALID as presented to the slave.
- ar_ready  in  1  ARREADY from the slave.
- ar_block  out  1  high forces the AR mux to deassert ARVALID toward the slave.
- s_rvalid  in  1  slave RVALID.
- s_rready  out  1  RREADY to the slave.
- s_rdata  in  DATA_WIDTH  slave RDATA.
- s_rresp  in  2  slave RRESP.
- s_rlast  in  1  slave RLAST.
- s_rid  in  ID_WIDTH  slave RID.
- m_rvalid  out  NUM_MST  per-master RVALID.
- m_rready  in  NUM_MST  per-master RREADY.
- m_rdata  out  DATA_WIDTH  RDATA broadcast to all masters.
- m_rresp  out  2  RRESP broadcast.
- m_rlast  out  1  RLAST broadcast.
- m_rid  out  ID_WIDTH  RID broadcast.
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of outstanding bursts.
- err_orphan  out  1  sticky flag: R beat arrived with no outstanding burst.
- err_grant  out  1  sticky flag: AR handshake with a non-one-hot grant.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset clears the FIFO pointers, outst_cnt=0, err_orphan=0, err_grant=0. Outputs after reset: ar_block=0, s_rready=0, m_rvalid=0.
- Reset mid-burst drops all tracking immediately. Following beats are orphans: s_rready=0 and err_orphan is set.
- Push:
  - Condition: ar_valid & ar_ready & ~ar_block.
  - Data pushed: the binary-encoded index of ar_grant.
  - Timing: write on the rising edge; outst_cnt increments the next cycle.
- Non-one-hot grant at a push:
  - Zero grant: nothing is pushed and err_grant is set.
  - Multi-hot grant: the lowest set index is pushed and err_grant is set.
- ar_block = (outst_cnt == MAX_OUTST), decoded purely from registers.
  - No push when full, even if a pop happens in the same cycle; one cycle of lost throughput is accepted.
- Head select: head = FIFO read data, valid when outst_cnt ≠ 0.
- R steering is combinational, zero latency, no registering:
  - m_rvalid[i] = s_rvalid & nonempty & (head == i).
  - s_rready = nonempty & m_rready[head].
  - m_rdata, m_rresp, m_rlast and m_rid are direct wires from the slave.
- Pop:
  - Condition: s_rvalid & s_rready & s_rlast.
  - Non-last beats do not pop. A burst spans any number of beats.
- Simultaneous push and pop (not full): outst_cnt is unchanged and both pointers advance.
- Wrap-around: pointers carry one extra bit. Full/empty are derived from outst_cnt, not from pointer equality.
- Orphans: s_rvalid while empty leaves s_rready=0, so the slave stalls, and sets err_orphan. The error flags clear only on rst.
- Ordering: the slave returns bursts in AR order. RID is carried through only; it is not used for steering.
- AXI rule compliance:
  - No combinational path from s_rvalid to s_rready.
  - m_rvalid never depends on m_rready.
  - m_rvalid remains stable while stalled, because head changes only on a pop.

Decomposition:
- Shared package axi_pkg:
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Constant AXI_RESP_W=2.
  - Function onehot2bin(), also usable by the arbiter.
- One sub-module, sync_fifo (WIDTH, DEPTH): synchronous, registered count, push/pop/full/empty/rdata with first-word fall-through. It holds the master indices.

Test Plan:
- Single burst: grant=2'b10, AR handshake, then 4 beats with RLAST on beat 4 and m_rready[1]=1 → m_rvalid=2'b10 on all 4 beats; outst_cnt goes 0→1→0; m_rvalid[0] stays 0.
- Interleaved order: AR to M0, then M1, then M0; slave returns 2-beat bursts → beats route M0, M0, M1, M1, M0, M0; outst_cnt peaks at 3.
- Full: 4 ARs with no R → ar_block=1 and outst_cnt=4; a 5th ar_valid is not pushed; after the first RLAST pop, ar_block=0 the next cycle.
- Backpressure: m_rready[0]=0 for 3 cycles mid-burst → s_rready=0 for those cycles; m_rvalid stays 2'b01; no beat is lost; RDATA sequence 0xA0..0xA3 is delivered intact.
- Simultaneous push and pop at outst_cnt=2 → outst_cnt stays 2; the next burst routes to the newly pushed master in order.
- Errors: s_rvalid with empty FIFO → s_rready=0 and err_orphan=1 sticky; AR handshake with grant=2'b00 → err_grant=1 and outst_cnt unchanged; rst mid-burst → all counters return to 0.
